// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one UART byte serializer among NUM_SRC sources.
// Define UART_ARB_HEADER_EN to prefix each packet with header byte 8'hA0 | grant_id.
module uart_tx_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC-1:0]         s_valid,
    output logic [NUM_SRC-1:0]         s_ready,
    input  logic [8*NUM_SRC-1:0]       s_data,
    input  logic [NUM_SRC-1:0]         s_last,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [7:0]                 m_data,
    output logic                       busy,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic                       timeout
);

    // state | meaning
    // IDLE  | no grant held; arbitrate among s_valid (one cycle, no byte moves)
    // HDR   | header byte for the granted source (header build only)
    // PASS  | forward granted source until its last byte is accepted or watchdog fires

    localparam int GW   = $clog2(NUM_SRC);
    localparam int WD_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYC);
    localparam bit WD_EN = (TIMEOUT_CYC > 0);

`ifdef UART_ARB_HEADER_EN
    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, PASS = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, PASS = 2'd2} state_t;
`endif

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_q, timeout_d;

    logic [GW-1:0]   pick;
    logic [GW-1:0]   cand;
    logic            found;
    int              idx;
    logic            sel_valid;
    logic            sel_last;
    logic [7:0]      sel_data;

    assign sel_valid = s_valid[grant_q];
    assign sel_last  = s_last[grant_q];
    assign sel_data  = s_data[8*grant_q +: 8];

    // First requester after last_grant, wrapping modulo NUM_SRC.
    always_comb begin
        pick  = last_grant_q;
        found = 1'b0;
        idx   = 0;
        cand  = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            idx = int'(last_grant_q) + i;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            cand = GW'(idx);
            if (!found && s_valid[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        wd_cnt_d     = wd_cnt_q;
        timeout_d    = 1'b0;
        m_valid      = 1'b0;
        m_data       = '0;
        s_ready      = '0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d  = pick;
                    wd_cnt_d = WD_LOAD;
`ifdef UART_ARB_HEADER_EN
                    state_d  = HDR;
`else
                    state_d  = PASS;
`endif
                end
            end
`ifdef UART_ARB_HEADER_EN
            HDR: begin
                m_valid = 1'b1;
                m_data  = 8'hA0 | 8'(grant_q);
                if (m_ready) begin
                    wd_cnt_d = WD_LOAD;
                    state_d  = PASS;
                end
            end
`endif
            PASS: begin
                m_valid          = sel_valid;
                m_data           = sel_data;
                s_ready[grant_q] = m_ready;
                if (sel_valid && m_ready) begin
                    wd_cnt_d = WD_LOAD;
                    if (sel_last) begin
                        state_d      = IDLE;
                        last_grant_d = grant_q;
                    end
                end else if (!sel_valid && WD_EN) begin
                    // Down-counter reloaded on each accepted byte; expiry releases the grant.
                    if (wd_cnt_q > 1) begin
                        wd_cnt_d = wd_cnt_q - 1'b1;
                    end else begin
                        wd_cnt_d     = '0;
                        state_d      = IDLE;
                        last_grant_d = grant_q;
                        timeout_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_SRC - 1);
            wd_cnt_q     <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            wd_cnt_q     <= wd_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign grant_id = grant_q;
    assign timeout  = timeout_q;

endmodule
